// File: rtl/t8x8_tile_sched.sv
// Tile scheduler and flow controller for the 8x8 systolic transpose array.
// Optional perf counters enabled by defining T8X8_TILE_SCHED_PERF_EN.
module t8x8_tile_sched #(
    parameter int W   = 32,
    parameter int LAT = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8*W-1:0] in_data,
    input  logic [7:0]     in_clear,
    input  logic           in_mode,
    output logic           arr_enable,
    output logic           arr_start,
    output logic           arr_do_transpose,
    output logic [8*W-1:0] arr_x,
    output logic [7:0]     arr_mult_clear,
    input  logic [8*W-1:0] arr_z,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [8*W-1:0] out_data,
    output logic [2:0]     out_row,
    output logic           out_last,
    output logic [15:0]    perf_stall,
    output logic [15:0]    perf_tiles
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] row_cnt_q, row_cnt_d;
    logic       mode_q, mode_d;

    // Tag entry layout: {valid, row[2:0], last}
    logic [4:0] tag_q [LAT];
    logic [4:0] tag_push;

    logic out_stall;
    logic in_stall;
    logic pipe_empty;
    logic mode_ok;
    logic tile_start;
    logic accept;

    assign out_valid = tag_q[LAT-1][4];
    assign out_row   = tag_q[LAT-1][3:1];
    assign out_last  = tag_q[LAT-1][0];
    assign out_data  = arr_z;

    assign out_stall = out_valid & ~out_ready;
    assign in_stall  = (state_q == LOAD) & (row_cnt_q != 3'd0) & ~in_valid;

    // Pipeline is empty when no in-flight tag is valid
    always_comb begin
        pipe_empty = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            if (tag_q[i][4]) pipe_empty = 1'b0;
        end
    end

    assign mode_ok    = pipe_empty | (in_mode == mode_q);
    assign tile_start = in_valid & ~out_stall & (row_cnt_q == 3'd0) & mode_ok;

    assign in_ready = ~out_stall
                    & (((state_q == LOAD) & (row_cnt_q != 3'd0)) | tile_start);
    assign accept   = in_valid & in_ready;

    assign arr_enable = ~out_stall & ~in_stall
                      & ((state_q != IDLE) | tile_start);

    assign arr_start        = (state_q != IDLE);
    assign arr_do_transpose = mode_q;
    assign arr_x            = accept ? in_data  : '0;
    assign arr_mult_clear   = accept ? in_clear : 8'd0;

    assign tag_push = {accept, accept ? row_cnt_q : 3'd0,
                       accept & (row_cnt_q == 3'd7)};

    // Next-state, row counter and mode, advanced only on enabled cycles
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        mode_d    = mode_q;
        if (arr_enable) begin
            unique case (state_q)
                IDLE: begin
                    if (tile_start) begin
                        state_d   = LOAD;
                        row_cnt_d = 3'd1;
                        mode_d    = in_mode;
                    end
                end
                LOAD: begin
                    row_cnt_d = row_cnt_q + 3'd1;
                    if (row_cnt_q == 3'd7) state_d = DRAIN;
                end
                DRAIN: begin
                    if (tile_start) begin
                        state_d   = LOAD;
                        row_cnt_d = 3'd1;
                        mode_d    = in_mode;
                    end else if ((row_cnt_q == 3'd0) && pipe_empty) begin
                        state_d   = IDLE;
                        row_cnt_d = 3'd0;
                    end else begin
                        row_cnt_d = row_cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    row_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            row_cnt_q <= 3'd0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            mode_q    <= mode_d;
        end
    end

    // Tag shift register tracking rows through the array latency
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= 5'd0;
        end else if (arr_enable) begin
            tag_q[0] <= tag_push;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

`ifdef T8X8_TILE_SCHED_PERF_EN
    logic [15:0] stall_q;
    logic [15:0] tiles_q;

    // Stall cycles (saturating) and completed tiles (wrapping)
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'd0;
            tiles_q <= 16'd0;
        end else begin
            if ((state_q != IDLE) && !arr_enable && (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
            if (out_valid && out_ready && out_last)
                tiles_q <= tiles_q + 16'd1;
        end
    end

    assign perf_stall = stall_q;
    assign perf_tiles = tiles_q;
`else
    assign perf_stall = 16'd0;
    assign perf_tiles = 16'd0;
`endif

endmodule
